// File: rtl/sdmac_fifo_if.sv
// Bus bundle between the input datapath / DMA control and the sdmac_fifo.
// Optional watermark signals appear only when SDMAC_FIFO_WATERMARK_EN is defined.
interface sdmac_fifo_if #(
  parameter int DEPTH_LOG2 = 3
);
  logic                  FIFO_CLR;
  logic [31:0]           MID;
  logic                  WR_LONG;
  logic                  WR_BYTE;
  logic                  FLUSH;
  logic                  RD;
  logic [31:0]           FIFO_OD;
  logic [1:0]            BO;
  logic                  EMPTY;
  logic                  FULL;
  logic [DEPTH_LOG2:0]   COUNT;
  logic                  OVF;
  logic                  UNF;
`ifdef SDMAC_FIFO_WATERMARK_EN
  logic [DEPTH_LOG2:0]   WMARK;
  logic                  WM_HIT;

  modport master (
    output FIFO_CLR, MID, WR_LONG, WR_BYTE, FLUSH, RD, WMARK,
    input  FIFO_OD, BO, EMPTY, FULL, COUNT, OVF, UNF, WM_HIT
  );
  modport slave (
    input  FIFO_CLR, MID, WR_LONG, WR_BYTE, FLUSH, RD, WMARK,
    output FIFO_OD, BO, EMPTY, FULL, COUNT, OVF, UNF, WM_HIT
  );
`else
  modport master (
    output FIFO_CLR, MID, WR_LONG, WR_BYTE, FLUSH, RD,
    input  FIFO_OD, BO, EMPTY, FULL, COUNT, OVF, UNF
  );
  modport slave (
    input  FIFO_CLR, MID, WR_LONG, WR_BYTE, FLUSH, RD,
    output FIFO_OD, BO, EMPTY, FULL, COUNT, OVF, UNF
  );
`endif
endinterface

// File: rtl/sdmac_fifo.sv
// 8x32 DMA FIFO with longword writes and big-endian byte-lane staging.
// Optional watermark output is enabled with the SDMAC_FIFO_WATERMARK_EN macro.
module sdmac_fifo #(
  parameter int DEPTH_LOG2 = 3
) (
  input logic        CLK,
  input logic        RST_,
  sdmac_fifo_if.slave bus
);
  localparam int                  DEPTH   = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] DEPTH_C = (DEPTH_LOG2+1)'(DEPTH);

  logic [31:0]           ram [DEPTH];
  logic [DEPTH_LOG2-1:0] wptr;
  logic [DEPTH_LOG2-1:0] rptr;
  logic [DEPTH_LOG2:0]   count;
  logic [DEPTH_LOG2:0]   count_next;
  logic [1:0]            bo;
  logic [1:0]            bo_next;
  logic [31:0]           staging;
  logic [31:0]           staging_next;
  logic [31:0]           assembled;
  logic [31:0]           commit_data;
  logic [31:0]           fifo_od;
  logic                  commit;
  logic                  ovf;
  logic                  ovf_set;
  logic                  unf;
  logic                  rd_ok;
  logic                  full;
  logic                  empty;

  assign full  = (count == DEPTH_C);
  assign empty = (count == '0);

  // Full is judged before any same-cycle pop, so a commit never lands in a slot freed this cycle.
  always_comb begin
    commit       = 1'b0;
    commit_data  = bus.MID;
    ovf_set      = 1'b0;
    staging_next = staging;
    bo_next      = bo;
    assembled    = staging;
    case (bo)
      2'd0:    assembled[31:24] = bus.MID[7:0];
      2'd1:    assembled[23:16] = bus.MID[7:0];
      2'd2:    assembled[15:8]  = bus.MID[7:0];
      default: assembled[7:0]   = bus.MID[7:0];
    endcase

    if (bus.WR_LONG) begin
      // Any partial staging is abandoned when a longword arrives.
      staging_next = '0;
      bo_next      = 2'd0;
      if (!full) begin
        commit      = 1'b1;
        commit_data = bus.MID;
      end else begin
        ovf_set = 1'b1;
      end
    end else if (bus.WR_BYTE) begin
      if (bo != 2'd3) begin
        staging_next = assembled;
        bo_next      = bo + 2'd1;
      end else if (!full) begin
        commit       = 1'b1;
        commit_data  = assembled;
        staging_next = '0;
        bo_next      = 2'd0;
      end else begin
        ovf_set = 1'b1;
      end
    end else if (bus.FLUSH && (bo != 2'd0)) begin
      if (!full) begin
        commit       = 1'b1;
        commit_data  = staging;
        staging_next = '0;
        bo_next      = 2'd0;
      end else begin
        ovf_set = 1'b1;
      end
    end
  end

  assign rd_ok      = bus.RD && !empty;
  assign count_next = count + {{DEPTH_LOG2{1'b0}}, commit} - {{DEPTH_LOG2{1'b0}}, rd_ok};

  always_ff @(posedge CLK or negedge RST_) begin
    if (!RST_) begin
      wptr    <= '0;
      rptr    <= '0;
      count   <= '0;
      bo      <= 2'd0;
      staging <= '0;
      fifo_od <= '0;
      ovf     <= 1'b0;
      unf     <= 1'b0;
    end else if (bus.FIFO_CLR) begin
      wptr    <= '0;
      rptr    <= '0;
      count   <= '0;
      bo      <= 2'd0;
      staging <= '0;
      fifo_od <= '0;
      ovf     <= 1'b0;
      unf     <= 1'b0;
    end else begin
      count   <= count_next;
      bo      <= bo_next;
      staging <= staging_next;
      if (commit) wptr <= wptr + 1'b1;
      if (rd_ok) begin
        fifo_od <= ram[rptr];
        rptr    <= rptr + 1'b1;
      end
      if (ovf_set) ovf <= 1'b1;
      if (bus.RD && empty) unf <= 1'b1;
    end
  end

  // Storage has no reset; FIFO_CLR and RST_ only move pointers.
  always_ff @(posedge CLK) begin
    if (RST_ && !bus.FIFO_CLR && commit) ram[wptr] <= commit_data;
  end

`ifdef SDMAC_FIFO_WATERMARK_EN
  logic wm_hit;
  always_ff @(posedge CLK or negedge RST_) begin
    if (!RST_)             wm_hit <= 1'b0;
    else if (bus.FIFO_CLR) wm_hit <= 1'b0;
    else                   wm_hit <= (count_next >= bus.WMARK);
  end
  assign bus.WM_HIT = wm_hit;
`endif

  assign bus.FIFO_OD = fifo_od;
  assign bus.BO      = bo;
  assign bus.EMPTY   = empty;
  assign bus.FULL    = full;
  assign bus.COUNT   = count;
  assign bus.OVF     = ovf;
  assign bus.UNF     = unf;
endmodule

// File: tb/tb_sdmac_fifo.sv
// Directed bench for sdmac_fifo: fill/drain, byte staging, flush, wrap
// with an expected queue, and async reset / FIFO_CLR behaviour.
module tb_sdmac_fifo;
  logic CLK;
  logic RST_;
  int   checks = 0;
  int   errors = 0;
  logic [31:0] exp_q[$];

  sdmac_fifo_if #(.DEPTH_LOG2(3)) bus ();

  sdmac_fifo #(.DEPTH_LOG2(3)) dut (
    .CLK (CLK),
    .RST_(RST_),
    .bus (bus)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // One clock with the given strobes; returns 1ns after the edge with strobes cleared.
  task automatic cyc(input logic wl, input logic wb, input logic fl, input logic rd,
                     input logic clr, input logic [31:0] d);
    bus.WR_LONG  = wl;
    bus.WR_BYTE  = wb;
    bus.FLUSH    = fl;
    bus.RD       = rd;
    bus.FIFO_CLR = clr;
    bus.MID      = d;
    @(posedge CLK);
    #1;
    bus.WR_LONG  = 1'b0;
    bus.WR_BYTE  = 1'b0;
    bus.FLUSH    = 1'b0;
    bus.RD       = 1'b0;
    bus.FIFO_CLR = 1'b0;
  endtask

  task automatic check_reset_state(input string pfx);
    check({pfx, "_count"}, 32'(bus.COUNT), 32'd0);
    check({pfx, "_empty"}, 32'(bus.EMPTY), 32'd1);
    check({pfx, "_full"},  32'(bus.FULL),  32'd0);
    check({pfx, "_bo"},    32'(bus.BO),    32'd0);
    check({pfx, "_od"},    bus.FIFO_OD,    32'd0);
    check({pfx, "_ovf"},   32'(bus.OVF),   32'd0);
    check({pfx, "_unf"},   32'(bus.UNF),   32'd0);
  endtask

  // Brings the FIFO to COUNT=5, BO=2, FIFO_OD=1, UNF=1.
  task automatic setup_midstream();
    cyc(0, 0, 0, 1, 0, 32'h0);
    for (int i = 1; i <= 6; i++) cyc(1, 0, 0, 0, 0, 32'(i));
    cyc(0, 0, 0, 1, 0, 32'h0);
    cyc(0, 1, 0, 0, 0, 32'h0000_00E1);
    cyc(0, 1, 0, 0, 0, 32'h0000_00E2);
    check("mid_count", 32'(bus.COUNT),  32'd5);
    check("mid_bo",    32'(bus.BO),     32'd2);
    check("mid_od",    bus.FIFO_OD,     32'd1);
    check("mid_unf",   32'(bus.UNF),    32'd1);
  endtask

  // 0 idle, 1 write, 2 read, 3 write+read
  int ops [20] = '{1,1,1,3,3,2,1,1,1,3,1,1,3,2,2,3,1,2,2,2};

  initial begin
    logic [31:0] exp_od;
    logic [31:0] wdata;
    bit          do_wr, do_rd, can_wr, can_rd;

    bus.FIFO_CLR = 1'b0;
    bus.MID      = '0;
    bus.WR_LONG  = 1'b0;
    bus.WR_BYTE  = 1'b0;
    bus.FLUSH    = 1'b0;
    bus.RD       = 1'b0;
`ifdef SDMAC_FIFO_WATERMARK_EN
    bus.WMARK    = 4'd4;
`endif
    RST_ = 1'b0;
    repeat (3) @(posedge CLK);
    #1;
    check_reset_state("reset");
    RST_ = 1'b1;
    @(posedge CLK);
    #1;

    // Fill to full, then overflow.
    for (int i = 1; i <= 8; i++) cyc(1, 0, 0, 0, 0, 32'h1111_1111 * i);
    check("fill_full",  32'(bus.FULL),  32'd1);
    check("fill_count", 32'(bus.COUNT), 32'd8);
    check("fill_ovf",   32'(bus.OVF),   32'd0);
`ifdef SDMAC_FIFO_WATERMARK_EN
    check("fill_wm_hit", 32'(bus.WM_HIT), 32'd1);
`endif
    cyc(1, 0, 0, 0, 0, 32'hDEAD_BEEF);
    check("ovf_set",   32'(bus.OVF),   32'd1);
    check("ovf_count", 32'(bus.COUNT), 32'd8);

    // Drain in order, then underflow.
    for (int i = 1; i <= 8; i++) begin
      cyc(0, 0, 0, 1, 0, 32'h0);
      check($sformatf("drain_od%0d", i), bus.FIFO_OD, 32'h1111_1111 * i);
    end
    check("drain_empty", 32'(bus.EMPTY), 32'd1);
    check("drain_unf0",  32'(bus.UNF),   32'd0);
    cyc(0, 0, 0, 1, 0, 32'h0);
    check("unf_set",  32'(bus.UNF), 32'd1);
    check("unf_hold", bus.FIFO_OD,  32'h8888_8888);

    cyc(0, 0, 0, 0, 1, 32'h0);
    check_reset_state("clr1");

    // Four bytes assemble big-endian into one entry.
    cyc(0, 1, 0, 0, 0, 32'h0000_00AA);
    check("byte_bo1", 32'(bus.BO), 32'd1);
    cyc(0, 1, 0, 0, 0, 32'h0000_00BB);
    check("byte_bo2", 32'(bus.BO), 32'd2);
    cyc(0, 1, 0, 0, 0, 32'h0000_00CC);
    check("byte_bo3", 32'(bus.BO), 32'd3);
    check("byte_count_pre", 32'(bus.COUNT), 32'd0);
    cyc(0, 1, 0, 0, 0, 32'h0000_00DD);
    check("byte_bo0",   32'(bus.BO),    32'd0);
    check("byte_count", 32'(bus.COUNT), 32'd1);
    cyc(0, 0, 0, 1, 0, 32'h0);
    check("byte_od", bus.FIFO_OD, 32'hAABB_CCDD);

    // Partial staging committed by FLUSH with zero-filled lanes.
    cyc(0, 1, 0, 0, 0, 32'h0000_0012);
    cyc(0, 1, 0, 0, 0, 32'h0000_0034);
    cyc(0, 0, 1, 0, 0, 32'h0);
    check("flush_count", 32'(bus.COUNT), 32'd1);
    check("flush_bo",    32'(bus.BO),    32'd0);
    cyc(0, 0, 1, 0, 0, 32'h0);
    check("flush_noop",  32'(bus.COUNT), 32'd1);
    cyc(0, 0, 0, 1, 0, 32'h0);
    check("flush_od", bus.FIFO_OD, 32'h1234_0000);

    // Simultaneous write and read at COUNT=3.
    for (int i = 0; i < 3; i++) begin
      cyc(1, 0, 0, 0, 0, 32'hA000_0000 + 32'(i));
      exp_q.push_back(32'hA000_0000 + 32'(i));
    end
    check("wr_rd_pre", 32'(bus.COUNT), 32'd3);
    cyc(1, 0, 0, 1, 0, 32'hA000_0003);
    exp_od = exp_q.pop_front();
    exp_q.push_back(32'hA000_0003);
    check("wr_rd_count", 32'(bus.COUNT), 32'd3);
    check("wr_rd_od",    bus.FIFO_OD,    exp_od);

    // Mixed operations across the pointer wrap, checked against the expected queue.
    for (int i = 0; i < 20; i++) begin
      do_wr  = (ops[i] == 1) || (ops[i] == 3);
      do_rd  = (ops[i] == 2) || (ops[i] == 3);
      can_wr = exp_q.size() < 8;
      can_rd = exp_q.size() > 0;
      wdata  = 32'hC000_0000 + 32'(i);
      cyc(do_wr, 0, 0, do_rd, 0, wdata);
      if (do_rd && can_rd) begin
        exp_od = exp_q.pop_front();
        check($sformatf("mix_od%0d", i), bus.FIFO_OD, exp_od);
      end
      if (do_wr && can_wr) exp_q.push_back(wdata);
      check($sformatf("mix_count%0d", i), 32'(bus.COUNT), 32'(exp_q.size()));
    end
    check("mix_ovf", 32'(bus.OVF), 32'd1);
    while (exp_q.size() > 0) begin
      cyc(0, 0, 0, 1, 0, 32'h0);
      exp_od = exp_q.pop_front();
      check("mix_drain_od", bus.FIFO_OD, exp_od);
    end
    check("mix_empty", 32'(bus.EMPTY), 32'd1);

    // Asynchronous reset in the middle of a cycle.
    cyc(0, 0, 0, 0, 1, 32'h0);
    setup_midstream();
    #2;
    RST_ = 1'b0;
    #1;
    check_reset_state("arst");
    @(posedge CLK);
    #1;
    RST_ = 1'b1;
    @(posedge CLK);
    #1;

    // Synchronous clear from the same state.
    setup_midstream();
    cyc(1, 1, 1, 1, 1, 32'hFFFF_FFFF);
    check_reset_state("fclr");

    // Staging was emptied by the clear: one byte then FLUSH yields only that byte.
    cyc(0, 1, 0, 0, 0, 32'h0000_0055);
    cyc(0, 0, 1, 0, 0, 32'h0);
    cyc(0, 0, 0, 1, 0, 32'h0);
    check("post_clr_od", bus.FIFO_OD, 32'h5500_0000);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/sdmac_fifo.md
Name: sdmac_fifo

Overview:
- Downstream consumer of the input datapath's MID bus; buffers DMA data between the 32-bit host side and the SCSI side.
- 8-entry x 32-bit synchronous FIFO, with two write modes:
  - full longword writes;
  - byte-lane writes assembled big-endian in a staging register.
- Registered read data feeds the output datapath; occupancy flags feed the DMA control state machine.

Parameters:
- DEPTH_LOG2, 3, log2 of entry count (8 entries); COUNT width is DEPTH_LOG2+1.

Ports:
- CLK  in  1  system clock; all state on rising edge.
- RST_  in  1  asynchronous active-low reset.
- FIFO_CLR  in  1  synchronous clear of pointers, staging, flags; data RAM untouched.
- MID  in  32  write data from input datapath.
- WR_LONG  in  1  write MID[31:0] as one entry.
- WR_BYTE  in  1  write MID[7:0] into staging lane BO.
- FLUSH  in  1  commit partially filled staging register.
- RD  in  1  pop one entry.
- FIFO_OD  out  32  registered read data.
- BO  out  2  current byte-lane pointer.
- EMPTY  out  1  COUNT==0.
- FULL  out  1  COUNT==8.
- COUNT  out  4  occupancy 0..8.
- OVF  out  1  sticky overflow.
- UNF  out  1  sticky underflow.

Behaviour:
- Reset (RST_ low, async): WPTR=RPTR=0, COUNT=0, BO=0, staging=0, FIFO_OD=0, EMPTY=1, FULL=0, OVF=0, UNF=0.
- FIFO_CLR: same values as reset, applied at the clock edge; it has priority over every other input that cycle.
- Pointers: 3-bit WPTR/RPTR wrap 7->0. COUNT is tracked explicitly; FULL and EMPTY decode from COUNT.
- WR_LONG:
  - If !FULL: RAM[WPTR]<=MID, WPTR++, COUNT++.
  - If FULL: write dropped, OVF<=1.
  - WR_LONG while BO!=0 is a protocol error: staging is discarded, BO<=0, the longword is written normally.
- WR_BYTE: lane mapping big-endian: BO=0 -> staging[31:24], BO=1 -> [23:16], BO=2 -> [15:8], BO=3 -> [7:0].
  - BO<3: store byte, BO++.
  - BO==3 and !FULL: the assembled longword (with the new byte in [7:0]) commits to RAM[WPTR] that cycle. WPTR++, COUNT++, BO<=0, staging<=0.
  - BO==3 and FULL: byte dropped, BO unchanged, OVF<=1.
- FLUSH:
  - BO!=0 and !FULL: commit staging with unwritten lanes zero, BO<=0.
  - BO!=0 and FULL: OVF<=1, staging held.
  - BO==0: no-op.
  - FLUSH is ignored in the same cycle as WR_BYTE or WR_LONG; write priority order is WR_LONG > WR_BYTE > FLUSH.
- RD:
  - If !EMPTY: FIFO_OD<=RAM[RPTR], RPTR++, COUNT--; 1-cycle latency, so data is valid the cycle after RD.
  - If EMPTY: FIFO_OD holds, UNF<=1.
- Simultaneous commit and RD:
  - Neither full nor empty: both occur, COUNT unchanged.
  - EMPTY: read underflows (UNF<=1), write commits; no fall-through.
  - FULL: read occurs; write dropped, OVF<=1 (full is evaluated before the pop).
- Reset mid-operation: partial staging bytes are lost; no commit occurs.

Optional Feature:
- Macro SDMAC_FIFO_WATERMARK_EN.
- Defined:
  - Adds input WMARK[3:0] and output WM_HIT.
  - WM_HIT is registered: 1 when the next-state COUNT >= WMARK, else 0; reset value 0.
  - WMARK=0 forces WM_HIT=1 after the first clock out of reset.
- Undefined: ports absent, no logic.

Test Plan:
- Reset, then 8 WR_LONG of 0x11111111..0x88888888 -> FULL=1, COUNT=8. A 9th write 0xDEADBEEF -> dropped, OVF=1.
- 8 RD pops from that full FIFO -> FIFO_OD sequence 0x11111111..0x88888888, each one cycle after RD. EMPTY=1 after the last. An extra RD -> UNF=1, FIFO_OD stays 0x88888888.
- WR_BYTE 0xAA,0xBB,0xCC,0xDD -> BO steps 1,2,3,0. COUNT=1. RD -> FIFO_OD=0xAABBCCDD.
- WR_BYTE 0x12, 0x34, then FLUSH -> COUNT=1, BO=0. RD -> FIFO_OD=0x12340000.
- COUNT=3, WR_LONG and RD in the same cycle -> COUNT stays 3. Pointer wrap across 7->0 over 20 mixed operations matches the scoreboard.
- Mid-stream: COUNT=5, BO=2, assert RST_ low asynchronously -> all outputs return to reset values before the next edge. FIFO_CLR gives the same result synchronously.
